// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl
//   Multi-cycle signed multiply/divide unit for the execute stage. It picks
//   up the mul/div instructions that the ALU path skips. It freezes the
//   pipeline while it iterates, then presents the result for the X/M latch.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   DXIR       D/X instruction; opcode [31:27], ALU op [6:2]
//   operandA   rs value (post-bypass)
//   operandB   rt value (post-bypass)
//   dxEn       D/X latch enable from the other stall sources (1 = advancing)
//   stall      freeze PC, F/D and D/X; bubble X/M
//   result     product/quotient, valid while resultRdy
//   resultRdy  result/exception valid for the X/M latch this cycle
//   exception  mul overflow, div overflow or div by zero
//   mdIsDiv    completed op was a divide
//
// state | meaning
// IDLE  | waiting; a mul/div in DXIR stalls and latches magnitudes
// BUSY  | one shift-add / restoring-divide iteration per cycle
// DONE  | result presented; leaves when the D/X latch advances

module mult_div_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      DXIR,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             dxEn,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             resultRdy,
  output logic             exception,
  output logic             mdIsDiv
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   hi, lo, mcand, res_reg;
  logic               neg, is_div, exc_reg;

  logic               is_mul_op, is_div_op, is_md;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               last_iter;

  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   hi_nxt, lo_nxt, quo_s;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic               mul_ovf, div_ovf;
  logic               unused_bits;

  assign is_mul_op = (DXIR[31:27] == 5'd0) && (DXIR[6:2] == 5'd6);
  assign is_div_op = (DXIR[31:27] == 5'd0) && (DXIR[6:2] == 5'd7);
  assign is_md     = is_mul_op | is_div_op;

  // Magnitudes are unsigned, so |-2^(W-1)| still fits in WIDTH bits.
  assign a_neg  = operandA[WIDTH-1];
  assign b_neg  = operandB[WIDTH-1];
  assign a_mag  = a_neg ? -operandA : operandA;
  assign b_mag  = b_neg ? -operandB : operandB;
  assign b_zero = (operandB == '0);

  assign last_iter = (count == CNT_W'(ITER - 1));

  // Multiply: {hi,lo} starts as {0, multiplier}; add multiplicand into hi
  // when lo[0] is set, then shift the whole pair right with the carry.
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

  // Divide: hi is the partial remainder, lo shifts the dividend out and the
  // quotient bits in.
  assign div_sh   = {hi, lo[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, mcand});
  assign div_diff = div_sh - {1'b0, mcand};

  assign hi_nxt = is_div ? (div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0])
                         : mul_sum[WIDTH:1];
  assign lo_nxt = is_div ? {lo[WIDTH-2:0], div_ge}
                         : {mul_sum[0], lo[WIDTH-1:1]};

  assign prod   = {hi_nxt, lo_nxt};
  assign prod_s = neg ? -prod : prod;
  assign quo_s  = neg ? -lo_nxt : lo_nxt;

  // Product fits only if its top WIDTH+1 bits are all equal.
  assign mul_ovf = ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));
  // A positive quotient of magnitude 2^(W-1) only arises from MIN / -1.
  assign div_ovf = ~neg & lo_nxt[WIDTH-1];

  assign unused_bits = ^{DXIR[26:7], DXIR[1:0], div_diff[WIDTH]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    result    = '0;
    resultRdy = 1'b0;
    exception = 1'b0;
    mdIsDiv   = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so every output reads zero while reset is held.
        stall = is_md & ~reset;
        if (is_md) state_nxt = (is_div_op && b_zero) ? DONE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        resultRdy = 1'b1;
        result    = res_reg;
        exception = exc_reg;
        mdIsDiv   = is_div;
        if (dxEn) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      neg     <= 1'b0;
      is_div  <= 1'b0;
      res_reg <= '0;
      exc_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            count  <= '0;
            hi     <= '0;
            lo     <= a_mag;
            mcand  <= b_mag;
            neg    <= a_neg ^ b_neg;
            is_div <= is_div_op;
            if (is_div_op && b_zero) begin
              res_reg <= '0;
              exc_reg <= 1'b1;
            end
          end
        end
        BUSY: begin
          hi    <= hi_nxt;
          lo    <= lo_nxt;
          count <= count + 1'b1;
          if (last_iter) begin
            res_reg <= is_div ? quo_s : prod_s[WIDTH-1:0];
            exc_reg <= is_div ? div_ovf : mul_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl
//   Drives mul/div instructions into mult_div_ctrl and checks results through
//   a queue of expected responses filled from an arithmetic reference model.

module tb_mult_div_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] DXIR;
  logic [31:0] operandA, operandB;
  logic        dxEn;
  logic        stall;
  logic [31:0] result;
  logic        resultRdy, exception, mdIsDiv;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
    logic        dv;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_rdy = 1'b0;

  mult_div_ctrl dut (
    .clock(clock), .reset(reset), .DXIR(DXIR),
    .operandA(operandA), .operandB(operandB), .dxEn(dxEn),
    .stall(stall), .result(result), .resultRdy(resultRdy),
    .exception(exception), .mdIsDiv(mdIsDiv)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input bit dv, input logic [31:0] a, input logic [31:0] b);
    exp_t   m;
    longint p;
    int     sa, sb;
    m.dv = dv;
    if (!dv) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      m.res = p[31:0];
      m.exc = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      m.res = 32'd0;
      m.exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      m.res = 32'h8000_0000;
      m.exc = 1'b1;
    end else begin
      sa    = a;
      sb    = b;
      m.res = sa / sb;
      m.exc = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [31:0] mk_ir(input bit dv);
    logic [31:0] r;
    r        = $urandom;
    r[31:27] = 5'd0;
    r[6:2]   = dv ? 5'd7 : 5'd6;
    return r;
  endfunction

  function automatic logic [31:0] nonmd();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 1) == 1) r[31:27] = 5'd0;
    if (r[31:27] == 5'd0 && (r[6:2] == 5'd6 || r[6:2] == 5'd7)) r[6:2] = 5'd0;
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($signed($urandom_range(0, 40)) - 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one mul/div, count its stall cycles, optionally hold DONE.
  task automatic do_op(input bit dv, input logic [31:0] a, input logic [31:0] b, input int hold);
    int          n;
    logic [31:0] s_res;
    logic        s_exc, s_dv;
    sbq.push_back(model(dv, a, b));
    @(negedge clock);
    DXIR = mk_ir(dv); operandA = a; operandB = b; dxEn = 1'b1;
    #1;
    if (resultRdy) begin
      @(negedge clock);
      #1;
    end
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      n++;
      @(negedge clock);
      DXIR = $urandom; operandA = $urandom; operandB = $urandom;
      if (hold > 0) dxEn = 1'b0;
      #1;
    end
    chk("stall_cycles", n, (dv && b == 32'd0) ? 1 : 33);
    chk("rdy_after_stall", resultRdy, 1);
    s_res = result; s_exc = exception; s_dv = mdIsDiv;
    repeat (hold) begin
      @(negedge clock);
      #1;
      chk("hold_stall", stall, 0);
      chk("hold_rdy", resultRdy, 1);
      chk("hold_result", result, s_res);
      chk("hold_exc", exception, s_exc);
      chk("hold_isdiv", mdIsDiv, s_dv);
    end
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin
      @(negedge clock);
      DXIR = nonmd(); operandA = $urandom; operandB = $urandom; dxEn = 1'($urandom);
      #1;
      chk("idle_stall", stall, 0);
      chk("idle_rdy", resultRdy, 0);
    end
  endtask

  // Scoreboard monitor: compares each newly presented result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (resultRdy === 1'b1 && !prev_rdy) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got result %h, nothing expected", result);
        end else begin
          e = sbq.pop_front();
          chk("result", result, e.res);
          chk("exception", exception, e.exc);
          chk("mdIsDiv", mdIsDiv, e.dv);
        end
      end
      prev_rdy = (resultRdy === 1'b1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dv;
    int hold;
    reset = 1'b1; DXIR = 32'd0; operandA = 32'd0; operandB = 32'd0; dxEn = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_rdy", resultRdy, 0);
    chk("rst_result", result, 0);
    chk("rst_exc", exception, 0);
    chk("rst_isdiv", mdIsDiv, 0);
    @(negedge clock);
    reset = 1'b0;
    idle_cycles(2);

    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0);
    do_op(1'b0, 32'h0001_0000, 32'h0001_0000, 0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b1, 32'd5, 32'd0, 0);
    idle_cycles(1);
    do_op(1'b0, 32'd11, 32'd13, 3);
    do_op(1'b0, 32'd2, 32'd3, 0);
    do_op(1'b1, 32'd9, 32'd0, 2);
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle_cycles(2);

    for (int i = 0; i < 40; i++) begin
      dv   = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      do_op(dv, pick(), pick(), hold);
      if (hold == 0 && $urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end
    do_op(1'b1, 32'd100, 32'd7, 0);
    idle_cycles(2);

    // Abort a multiply partway through with reset.
    @(negedge clock);
    DXIR = mk_ir(1'b0); operandA = $urandom; operandB = $urandom; dxEn = 1'b1;
    repeat (11) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_stall", stall, 0);
    chk("abort_rdy", resultRdy, 0);
    chk("abort_result", result, 0);
    chk("abort_exc", exception, 0);
    chk("abort_isdiv", mdIsDiv, 0);
    @(negedge clock);
    reset = 1'b0;
    DXIR  = 32'd0;
    #1;
    chk("add_stall", stall, 0);
    idle_cycles(40);

    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    idle_cycles(2);
    chk("queue_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
